// File: rtl/lcd_cmd_engine.sv
// HD44780 write-only command engine: a 4-deep {rs, data} FIFO feeds a timed
// SETUP / PULSE / HOLD / WAIT sequencer that drives the panel pins.
module lcd_cmd_engine #(
  parameter int unsigned SETUP_CYC      = 2,
  parameter int unsigned EN_CYC         = 12,
  parameter int unsigned HOLD_CYC       = 2,
  parameter int unsigned WAIT_CYC       = 2000,
  parameter int unsigned CLEAR_WAIT_CYC = 82000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_vld,
  input  logic       i_cmd_rs,
  input  logic [7:0] i_cmd_data,
  input  logic       i_lcd_on,
  output logic       o_cmd_rdy,
  output logic       o_busy,
  output logic [2:0] o_fifo_cnt,
  output logic       o_lcd_on,
  output logic       o_lcd_en,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_data
);

  // Phase counter counts down from (phase length - 1), so it must hold the
  // longest phase minus one.
  localparam int unsigned MAX_A   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int unsigned MAX_B   = (HOLD_CYC > WAIT_CYC) ? HOLD_CYC : WAIT_CYC;
  localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_CYC = (MAX_C > CLEAR_WAIT_CYC) ? MAX_C : CLEAR_WAIT_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } state_t;

  // FIFO state
  logic [8:0]       mem_q [4];
  logic [1:0]       wptr_q;
  logic [1:0]       rptr_q;
  logic [2:0]       cnt_q;
  logic [2:0]       cnt_d;
  logic             push;
  logic             pop;
  logic [8:0]       head;

  // Sequencer state
  state_t           state_q;
  logic [CNT_W-1:0] phase_q;
  logic             phase_done;
  logic             en_q;
  logic             rs_q;
  logic [7:0]       data_q;
  logic             lcd_on_q;
  logic             is_clear;

  // Push is gated by the pre-pop fullness, so a full FIFO rejects a write
  // even in the cycle it is popped.
  assign push       = i_cmd_vld && (cnt_q != 3'd4);
  assign pop        = (state_q == ST_IDLE) && lcd_on_q && (cnt_q != 3'd0);
  assign head       = mem_q[rptr_q];
  assign phase_done = (phase_q == '0);
  // Clear display (0x01) and return home (0x02) need the long execution wait.
  assign is_clear   = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));

  // Occupancy next-state: simultaneous push and pop leave the count unchanged.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO storage write; contents are only meaningful where the count says so.
  // NOTE: the storage array is deliberately not reset -- emptiness is carried
  // by the pointers and count, and leaving the array out of reset lets it map
  // onto plain registers or LUT RAM.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wptr_q] <= {i_cmd_rs, i_cmd_data};
  end

  // FIFO pointers and occupancy; 2-bit pointers wrap 3 -> 0 naturally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q <= 2'd0;
      rptr_q <= 2'd0;
      cnt_q  <= 3'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (push) wptr_q <= wptr_q + 2'd1;
      if (pop)  rptr_q <= rptr_q + 2'd1;
      cnt_q <= cnt_d;
    end
  end

  // Command sequencer: pop, then timed setup / enable pulse / hold / exec wait.
  // The phase counter reloads on every state entry and counts down to zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      en_q     <= 1'b0;
      rs_q     <= 1'b0;
      data_q   <= 8'h00;
      lcd_on_q <= 1'b0;
    end else begin
      lcd_on_q <= i_lcd_on;
      unique case (state_q)
        ST_IDLE: begin
          if (pop) begin
            rs_q    <= head[8];
            data_q  <= head[7:0];
            phase_q <= SETUP_LD;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (phase_done) begin
            phase_q <= PULSE_LD;
            en_q    <= 1'b1;
            state_q <= ST_PULSE;
          end else begin
            phase_q <= phase_q - CNT_W'(1);
          end
        end
        ST_PULSE: begin
          if (phase_done) begin
            phase_q <= HOLD_LD;
            en_q    <= 1'b0;
            state_q <= ST_HOLD;
          end else begin
            phase_q <= phase_q - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (phase_done) begin
            phase_q <= is_clear ? CLEAR_LD : WAIT_LD;
            state_q <= ST_WAIT;
          end else begin
            phase_q <= phase_q - CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (phase_done) begin
            state_q <= ST_IDLE;
          end else begin
            phase_q <= phase_q - CNT_W'(1);
          end
        end
        default: begin
          en_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are registers or decodes of registers only.
  assign o_cmd_rdy  = (cnt_q != 3'd4);
  assign o_busy     = (state_q != ST_IDLE) || (cnt_q != 3'd0);
  assign o_fifo_cnt = cnt_q;
  assign o_lcd_on   = lcd_on_q;
  assign o_lcd_en   = en_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_data = data_q;

endmodule

// File: tb/tb_lcd_cmd_engine.sv
// Directed bench for lcd_cmd_engine with short timing parameters.
module tb_lcd_cmd_engine;

  logic       clk;
  logic       rst;
  logic       cmd_vld;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       lcd_on;
  logic       cmd_rdy;
  logic       busy;
  logic [2:0] fifo_cnt;
  logic       lcd_on_o;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  lcd_cmd_engine #(
    .SETUP_CYC     (1),
    .EN_CYC        (3),
    .HOLD_CYC      (1),
    .WAIT_CYC      (4),
    .CLEAR_WAIT_CYC(10)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cmd_vld  (cmd_vld),
    .i_cmd_rs   (cmd_rs),
    .i_cmd_data (cmd_data),
    .i_lcd_on   (lcd_on),
    .o_cmd_rdy  (cmd_rdy),
    .o_busy     (busy),
    .o_fifo_cnt (fifo_cnt),
    .o_lcd_on   (lcd_on_o),
    .o_lcd_en   (lcd_en),
    .o_lcd_rs   (lcd_rs),
    .o_lcd_rw   (lcd_rw),
    .o_lcd_data (lcd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       prev_en;
    int         rises;
    int         n_emit;
    int         pushed;
    int         en_seen;
    logic [8:0] emitted [8];

    rst      = 1'b1;
    cmd_vld  = 1'b0;
    cmd_rs   = 1'b0;
    cmd_data = 8'h00;
    lcd_on   = 1'b1;
    for (int i = 0; i < 8; i++) emitted[i] = '0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_cnt",  fifo_cnt, 0);
    check("rst_rdy",  cmd_rdy,  1);
    check("rst_busy", busy,     0);
    check("rst_on",   lcd_on_o, 0);
    check("rst_en",   lcd_en,   0);
    check("rst_rs",   lcd_rs,   0);
    check("rst_rw",   lcd_rw,   0);
    check("rst_data", lcd_data, 8'h00);

    // Single data write; push lands on the first edge after release
    rst = 1'b0; cmd_vld = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h41;
    @(negedge clk);
    cmd_vld = 1'b0;
    check("t1_cnt_after_push", fifo_cnt, 1);
    check("t1_busy_queued",    busy,     1);
    @(negedge clk);
    check("t1_cnt_after_pop", fifo_cnt, 0);
    check("t1_rs",            lcd_rs,   1);
    check("t1_data",          lcd_data, 8'h41);
    check("t1_en_setup",      lcd_en,   0);
    check("t1_on",            lcd_on_o, 1);
    for (int k = 2; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("t1_en_k%0d", k),   lcd_en, (k >= 2 && k <= 4) ? 1 : 0);
      check($sformatf("t1_busy_k%0d", k), busy,   (k < 10) ? 1 : 0);
      check($sformatf("t1_data_k%0d", k), lcd_data, 8'h41);
    end

    // Clear command then data: long wait, push+pop in one cycle
    cmd_vld = 1'b1; cmd_rs = 1'b0; cmd_data = 8'h01;
    @(negedge clk);
    cmd_rs = 1'b1; cmd_data = 8'h42;
    @(negedge clk);
    cmd_vld = 1'b0;
    check("t2_pushpop_cnt", fifo_cnt, 1);
    check("t2_first_data",  lcd_data, 8'h01);
    check("t2_first_rs",    lcd_rs,   0);
    prev_en = lcd_en;
    rises   = 0;
    for (int k = 2; k <= 30; k++) begin
      @(negedge clk);
      if (lcd_en && !prev_en) rises++;
      prev_en = lcd_en;
      if (k == 16) check("t2_data_held_k16", lcd_data, 8'h01);
      if (k == 17) begin
        check("t2_second_data_k17", lcd_data, 8'h42);
        check("t2_second_rs_k17",   lcd_rs,   1);
      end
    end
    check("t2_en_rises", rises, 2);
    check("t2_idle",     busy,  0);

    // Power off: queue fills to 4, fifth dropped
    lcd_on = 1'b0;
    repeat (2) @(negedge clk);
    check("t3_on_off", lcd_on_o, 0);
    for (int i = 0; i < 5; i++) begin
      cmd_vld = 1'b1; cmd_rs = i[0]; cmd_data = 8'(8'hC0 + i);
      @(negedge clk);
    end
    cmd_vld = 1'b0;
    check("t3_full_cnt",  fifo_cnt, 4);
    check("t3_full_rdy",  cmd_rdy,  0);
    check("t3_full_busy", busy,     1);
    check("t3_no_en",     lcd_en,   0);
    // Power on; simultaneous push at full is rejected while the pop happens
    lcd_on = 1'b1;
    @(negedge clk);
    check("t3_cnt_before_pop", fifo_cnt, 4);
    cmd_vld = 1'b1; cmd_rs = 1'b0; cmd_data = 8'hEE;
    @(negedge clk);
    cmd_vld = 1'b0;
    check("t3_pop_at_full_cnt", fifo_cnt, 3);
    check("t3_pop_at_full_rdy", cmd_rdy,  1);
    check("t3_head_data",       lcd_data, 8'hC0);
    prev_en = lcd_en;
    n_emit  = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (lcd_en && !prev_en) begin
        if (n_emit < 8) emitted[n_emit] = {lcd_rs, lcd_data};
        n_emit++;
      end
      prev_en = lcd_en;
    end
    check("t3_emit_count", n_emit, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t3_emit%0d", i), emitted[i], {i[0], 8'(8'hC0 + i)});
    check("t3_drained", busy, 0);

    // Reset mid-pulse with two entries queued
    cmd_vld = 1'b1; cmd_rs = 1'b0; cmd_data = 8'h55;
    @(negedge clk);
    cmd_rs = 1'b1; cmd_data = 8'hA1;
    @(negedge clk);
    cmd_data = 8'hA2;
    @(negedge clk);
    cmd_vld = 1'b0;
    check("t4_in_pulse_en",   lcd_en,   1);
    check("t4_in_pulse_cnt",  fifo_cnt, 2);
    check("t4_in_pulse_data", lcd_data, 8'h55);
    #2 rst = 1'b1;
    #1;
    check("t4_async_en",   lcd_en,   0);
    check("t4_async_cnt",  fifo_cnt, 0);
    check("t4_async_busy", busy,     0);
    check("t4_async_rdy",  cmd_rdy,  1);
    check("t4_async_data", lcd_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    en_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (lcd_en) en_seen++;
    end
    check("t4_quiet_en",  en_seen,  0);
    check("t4_quiet_cnt", fifo_cnt, 0);
    cmd_vld = 1'b1; cmd_rs = 1'b0; cmd_data = 8'h66;
    @(negedge clk);
    cmd_vld = 1'b0;
    prev_en = lcd_en;
    n_emit  = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (lcd_en && !prev_en) begin
        if (n_emit < 8) emitted[n_emit] = {lcd_rs, lcd_data};
        n_emit++;
      end
      prev_en = lcd_en;
    end
    check("t4_new_emit_count", n_emit, 1);
    check("t4_new_emit",       emitted[0], {1'b0, 8'h66});

    // Six spaced commands: pointers wrap, order preserved
    pushed  = 0;
    n_emit  = 0;
    prev_en = lcd_en;
    for (int k = 0; k < 100; k++) begin
      if ((k % 6 == 0) && (pushed < 6)) begin
        cmd_vld = 1'b1; cmd_rs = pushed[0]; cmd_data = 8'(8'hA0 + pushed);
        pushed++;
      end else begin
        cmd_vld = 1'b0;
      end
      @(negedge clk);
      if (lcd_en && !prev_en) begin
        if (n_emit < 8) emitted[n_emit] = {lcd_rs, lcd_data};
        n_emit++;
      end
      prev_en = lcd_en;
    end
    cmd_vld = 1'b0;
    check("t5_emit_count", n_emit, 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("t5_emit%0d", i), emitted[i], {i[0], 8'(8'hA0 + i)});
    check("t5_drained", busy,     0);
    check("t5_cnt",     fifo_cnt, 0);
    check("t5_rw",      lcd_rw,   0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_engine.md
LCD_CMD_ENGINE -- requirements
Module: lcd_cmd_engine

Interface
REQ-001 Param SETUP_CYC, default 2, cycles that RS/DATA are stable before EN rises (min 1).
REQ-002 Param EN_CYC, default 12, EN high width in cycles (min 1).
REQ-003 Param HOLD_CYC, default 2, cycles that RS/DATA are held after EN falls (min 1).
REQ-004 Param WAIT_CYC, default 2000, post-command execution wait for normal commands (min 1).
REQ-005 Param CLEAR_WAIT_CYC, default 82000, post-command wait for clear/home (min 1).
REQ-006 Fixed: one clock; reset is asynchronous and active-high.
REQ-007 i_clk  in  1  sole clock, rising edge.
REQ-008 i_rst  in  1  async active-high reset.
REQ-009 i_cmd_vld  in  1  command write strobe from core LSU side.
REQ-010 i_cmd_rs  in  1  register select (0 = instruction, 1 = data).
REQ-011 i_cmd_data  in  8  command/character byte.
REQ-012 i_lcd_on  in  1  software LCD power enable.
REQ-013 o_cmd_rdy  out  1  FIFO not full.
REQ-014 o_busy  out  1  FSM not IDLE or FIFO non-empty.
REQ-015 o_fifo_cnt  out  3  entries queued, 0..4.
REQ-016 o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw  out  1 each  HD44780 panel pins.
REQ-017 o_lcd_data  out  8  HD44780 data bus.

Function
REQ-018 The command FIFO SHALL be 4 entries x 9 bits {rs, data}, first in, first out.
REQ-019 A push SHALL occur on a rising edge with i_cmd_vld=1 and o_cmd_rdy=1; i_cmd_vld while full SHALL be dropped with no state change.
REQ-020 A push and a pop in the same cycle SHALL both take effect, leaving o_fifo_cnt unchanged; at full, push is gated by o_cmd_rdy as computed before the pop.
REQ-021 Read/write pointers SHALL be 2 bits and wrap 3->0; o_fifo_cnt SHALL never exceed 4 or underflow.
REQ-022 The FSM SHALL have states IDLE, SETUP, PULSE, HOLD and WAIT.
REQ-023 IDLE: if o_lcd_on=1 and the FIFO is non-empty, pop the head, latch rs/data into output registers, go to SETUP next cycle; otherwise stay.
REQ-024 SETUP SHALL last exactly SETUP_CYC cycles with en=0, then go to PULSE.
REQ-025 PULSE SHALL last exactly EN_CYC cycles with en=1, then go to HOLD.
REQ-026 HOLD SHALL last exactly HOLD_CYC cycles with en=0, then go to WAIT.
REQ-027 WAIT SHALL last CLEAR_WAIT_CYC cycles if the latched rs=0 and data is 0x01 or 0x02, else WAIT_CYC cycles, then go to IDLE.
REQ-028 A command SHALL occupy 1+SETUP_CYC+EN_CYC+HOLD_CYC+wait cycles from pop to the next possible pop (2017 cycles with defaults for a normal command).
REQ-029 o_lcd_rs and o_lcd_data SHALL change only on the IDLE pop edge, and SHALL be constant through SETUP, PULSE, HOLD and WAIT.
REQ-030 o_lcd_rw SHALL be constant 0, since the engine is write-only and busy-flag polling is replaced by the timed WAIT.
REQ-031 o_lcd_on SHALL be i_lcd_on registered one cycle; while it is 0, queued commands SHALL stay queued, and an in-flight command SHALL complete.
REQ-032 The phase counter SHALL be wide enough for CLEAR_WAIT_CYC and SHALL reload on every state entry.
REQ-033 All outputs SHALL be registered or decoded directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-034 i_rst=1 SHALL immediately and asynchronously force state IDLE and empty the FIFO.
REQ-035 Under reset, o_fifo_cnt=0, o_cmd_rdy=1, o_busy=0, o_lcd_on=0, o_lcd_en=0, o_lcd_rs=0, o_lcd_rw=0 and o_lcd_data=0x00.
REQ-036 Reset asserted mid-PULSE SHALL drop o_lcd_en to 0 without waiting for a clock, and the in-flight command SHALL be lost.
REQ-037 After reset releases, the first push SHALL be accepted on the first rising edge.

Verification (SETUP_CYC=1, EN_CYC=3, HOLD_CYC=1, WAIT_CYC=4, CLEAR_WAIT_CYC=10, i_lcd_on=1)
REQ-038 Push {rs=1, 0x41} -> pop 1 cycle later; o_lcd_rs=1, o_lcd_data=0x41; o_lcd_en high exactly 3 cycles starting 2 cycles after pop; o_busy low 10 cycles after pop.
REQ-039 Push {rs=0, 0x01} then {rs=1, 0x42} -> second pop exactly 16 cycles after first pop; EN rises once per command.
REQ-040 With i_lcd_on=0, push 5 commands back-to-back -> first 4 accepted, o_fifo_cnt=4, o_cmd_rdy=0, 5th dropped; raise i_lcd_on -> 4 commands emitted in push order.
REQ-041 FIFO full, engine in IDLE, simultaneous push -> pop occurs, push rejected (o_cmd_rdy was 0), o_fifo_cnt=3.
REQ-042 Assert i_rst during PULSE of 0x55 with 2 entries queued -> o_lcd_en=0 immediately, o_fifo_cnt=0; after release no EN pulse until a new push.
REQ-043 Push 6 commands spaced for steady drain -> pointers wrap past 3, all 6 emitted in order, no loss or duplication.
